// File: rtl/aes256_key_schedule.sv
// aes256_key_schedule: iterative AES-256 key expansion, streams 15 round keys and stores the full schedule
module aes256_key_schedule #(
    parameter int NR = 14,
    parameter int NK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*NK-1:0]  key,
    output logic              busy,
    output logic              rk_valid,
    output logic [3:0]        rk_idx,
    output logic [127:0]      rk,
    output logic              done,
    output logic              sched_valid,
    input  logic [3:0]        rd_idx,
    output logic [127:0]      rd_key
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic         busy_q, busy_d, rk_valid_q, rk_valid_d, done_q, done_d, sched_valid_q, sched_valid_d;
    logic [3:0]   cnt_q, cnt_d, rk_idx_q, rk_idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] mem_q [NR+1];
    logic [127:0] mem_d [NR+1];
    logic [127:0] prev_rk, old_rk, gen;
    logic [31:0]  sub_in, sub_out, t0, g0, g1, g2, g3;
    // cnt_q is the index of the next round key to emit; 15 means the stream has finished
    always_comb begin
        prev_rk = mem_q[cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1];
        old_rk  = mem_q[cnt_q < 4'd2 ? 4'd0 : cnt_q - 4'd2];
        sub_in  = cnt_q[0] ? prev_rk[31:0] : {prev_rk[23:0], prev_rk[31:24]};
        sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
        t0      = cnt_q[0] ? sub_out : sub_out ^ {rcon_q, 24'h0};
        g0      = old_rk[127:96] ^ t0;
        g1      = old_rk[95:64] ^ g0;
        g2      = old_rk[63:32] ^ g1;
        g3      = old_rk[31:0] ^ g2;
        gen     = {g0, g1, g2, g3};
    end
    always_comb begin
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        rcon_d        = rcon_q;
        rk_d          = rk_q;
        rk_idx_d      = rk_idx_q;
        rk_valid_d    = 1'b0;
        done_d        = 1'b0;
        sched_valid_d = sched_valid_q;
        mem_d         = mem_q;
        if (!busy_q) begin
            if (start) begin
                busy_d        = 1'b1;
                cnt_d         = 4'd0;
                rcon_d        = 8'h01;
                sched_valid_d = 1'b0;
                mem_d[0]      = key[255:128];
                mem_d[1]      = key[127:0];
            end
        end else if (cnt_q == 4'd15) begin
            busy_d        = 1'b0;
            sched_valid_d = 1'b1;
        end else begin
            rk_valid_d = 1'b1;
            rk_idx_d   = cnt_q;
            rk_d       = cnt_q < 4'd2 ? (cnt_q[0] ? mem_q[1] : mem_q[0]) : gen;
            done_d     = cnt_q == 4'(NR);
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q >= 4'd2) begin
                mem_d[cnt_q] = gen;
                rcon_d       = cnt_q[0] ? rcon_q : {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= 1'b0;
            rk_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            sched_valid_q <= 1'b0;
            cnt_q         <= 4'd0;
            rk_idx_q      <= 4'd0;
            rcon_q        <= 8'h01;
            rk_q          <= '0;
            mem_q         <= '{default: '0};
        end else begin
            busy_q        <= busy_d;
            rk_valid_q    <= rk_valid_d;
            done_q        <= done_d;
            sched_valid_q <= sched_valid_d;
            cnt_q         <= cnt_d;
            rk_idx_q      <= rk_idx_d;
            rcon_q        <= rcon_d;
            rk_q          <= rk_d;
            mem_q         <= mem_d;
        end
    end
    assign busy        = busy_q;
    assign rk_valid    = rk_valid_q;
    assign rk_idx      = rk_idx_q;
    assign rk          = rk_q;
    assign done        = done_q;
    assign sched_valid = sched_valid_q;
    assign rd_key      = rd_idx > 4'(NR) ? '0 : mem_q[rd_idx == 4'd15 ? 4'd0 : rd_idx];
endmodule

// File: tb/tb_aes256_key_schedule.sv
// tb_aes256_key_schedule: known-answer table, random keys against a GF(2^8) reference model, and timing corner cases
module tb_aes256_key_schedule;
    logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [255:0] key = '0;
    logic [3:0]   rd_idx = '0;
    logic         busy, rk_valid, done, sched_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk, rd_key;
    int           checks = 0, errors = 0;
    logic [127:0] got [15];
    logic [127:0] exp_rk [15];
    typedef struct { logic [255:0] key; int idx; logic [127:0] rk; } vec_t;
    vec_t vecs [7];
    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEYA = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    always #20 clk = ~clk;
    aes256_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy), .rk_valid(rk_valid),
        .rk_idx(rk_idx), .rk(rk), .done(done), .sched_valid(sched_valid), .rd_idx(rd_idx), .rd_key(rd_key)
    );
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] v;
        v = '0;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction
    task automatic model(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) t = sub_w(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask
    // Call at a falling edge with busy low; returns at the falling edge after busy drops.
    task automatic expand(input logic [255:0] k, input bit poke);
        for (int i = 0; i < 15; i++) got[i] = 'x;
        start = 1'b1;
        key = k;
        @(negedge clk);
        start = 1'b0;
        key = ~k;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("sched_cleared", 128'(sched_valid), 128'(0));
        chk("no_rk_yet", 128'(rk_valid), 128'(0));
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 15) begin
                chk("rk_valid", 128'(rk_valid), 128'(1));
                chk("rk_idx", 128'(rk_idx), 128'(c - 1));
                chk("done_pulse", 128'(done), 128'(c == 15));
                chk("busy_stream", 128'(busy), 128'(1));
                got[c-1] = rk;
            end else begin
                chk("busy_end", 128'(busy), 128'(0));
                chk("rk_valid_end", 128'(rk_valid), 128'(0));
                chk("done_end", 128'(done), 128'(0));
                chk("sched_valid_end", 128'(sched_valid), 128'(1));
            end
            if (poke && c == 4) begin
                start = 1'b1;
                key = ~k;
            end
        end
    endtask
    task automatic verify_all(input logic [255:0] k);
        model(k);
        for (int r = 0; r < 15; r++) chk($sformatf("stream_rk%0d", r), got[r], exp_rk[r]);
        for (int r = 0; r < 16; r++) begin
            rd_idx = 4'(r);
            #1;
            chk($sformatf("rd_key%0d", r), rd_key, r < 15 ? exp_rk[r] : 128'h0);
        end
        chk("sched_valid_rd", 128'(sched_valid), 128'(1));
        @(negedge clk);
    endtask
    initial begin
        vecs[0] = '{KEY1, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{KEY1, 1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2] = '{KEY1, 2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3] = '{KEY1, 3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vecs[4] = '{KEY1, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[5] = '{KEYA, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[6] = '{KEYA, 14, 128'hfe4890d1e6188d0b046df344706c631e};
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rk_valid", 128'(rk_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_sched", 128'(sched_valid), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_rk", rk, 128'h0);
        chk("rst_rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 7; v++) begin
            expand(vecs[v].key, 1'b0);
            chk($sformatf("kat%0d_idx%0d", v, vecs[v].idx), got[vecs[v].idx], vecs[v].rk);
            verify_all(vecs[v].key);
        end
        expand(KEY1, 1'b1);
        verify_all(KEY1);
        start = 1'b1;
        key = KEY1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!(rk_valid && rk_idx == 4'd7) && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reach_idx7", 128'(n < 40), 128'(1));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_rk_valid", 128'(rk_valid), 128'(0));
        chk("midrst_sched", 128'(sched_valid), 128'(0));
        chk("midrst_rk", rk, 128'h0);
        rd_idx = 4'd0;
        #1 chk("midrst_rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expand(KEY1, 1'b0);
        verify_all(KEY1);
        #2 rst_n = 1'b0;
        #1 chk("idle_rst_sched", 128'(sched_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expand(KEY1, 1'b0);
        expand(KEYA, 1'b0);
        verify_all(KEYA);
        for (int n = 0; n < 4; n++) begin
            logic [255:0] rk_key;
            rk_key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            expand(rk_key, n[0]);
            verify_all(rk_key);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
